// File: rtl/dmem_dump_arbiter.sv
// rtl/dmem_dump_arbiter.sv - data-memory port arbiter between the MEM stage and a debug dump sequencer
// Optional starvation guard: define DMEM_DUMP_STARVE_GUARD_EN.
module dmem_dump_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_p_req,
    input  logic            i_p_we,
    input  logic [3:0]      i_p_be,
    input  logic [XLEN-1:0] i_p_addr,
    input  logic [XLEN-1:0] i_p_wdata,
    output logic [XLEN-1:0] o_p_rdata,
    output logic            o_p_stall,
    output logic            o_mem_re,
    output logic            o_mem_we,
    output logic [3:0]      o_mem_be,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_wdata,
    input  logic [XLEN-1:0] i_mem_rdata,
    input  logic            i_dump_start,
    input  logic [XLEN-1:0] i_dump_lo,
    input  logic [XLEN-1:0] i_dump_hi,
    output logic            o_dump_valid,
    input  logic            i_dump_ready,
    output logic [XLEN-1:0] o_dump_addr,
    output logic [XLEN-1:0] o_dump_data,
    output logic            o_dump_busy,
    output logic            o_dump_done
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [XLEN-1:0] r_cursor;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_dump_addr;
    logic [XLEN-1:0] r_dump_data;
    logic            r_dump_valid;
    logic            w_grant;
    logic            w_force;
    logic            w_hs;
    logic            w_range_end;
    logic [XLEN-1:0] w_lo_al;
    logic [XLEN-1:0] w_hi_al;
    logic [XLEN-1:0] w_cursor_inc;

    if (XLEN != 32) begin : g_xlen_check
        $error("dmem_dump_arbiter supports XLEN=32 only");
    end
    if (STARVE_LIMIT < 1) begin : g_limit_check
        $error("dmem_dump_arbiter needs STARVE_LIMIT >= 1");
    end

    // Dump ranges are word granular: low address bits are dropped on capture.
    assign w_lo_al      = {i_dump_lo[XLEN-1:2], 2'b00};
    assign w_hi_al      = {i_dump_hi[XLEN-1:2], 2'b00};
    assign w_cursor_inc = r_cursor + XLEN'(4);
    // A cursor that wraps past the top of the address space also ends the range.
    assign w_range_end  = (w_cursor_inc == '0) || (w_cursor_inc >= r_hi);
    assign w_hs         = r_dump_valid & i_dump_ready;
    assign w_grant      = (r_state == S_ISSUE) && (!i_p_req || w_force);

`ifdef DMEM_DUMP_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] r_starve;

    assign w_force = (r_state == S_ISSUE) && i_p_req && (r_starve == CW'(STARVE_LIMIT));

    // Count cycles the pipeline keeps the dump off the port; any dump grant clears it.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_starve <= '0;
        end else if (w_grant) begin
            r_starve <= '0;
        end else if ((r_state == S_ISSUE) && i_p_req) begin
            r_starve <= r_starve + CW'(1);
        end
    end
`else
    assign w_force = 1'b0;
`endif

    // Sequencer state register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a start pulse is only looked at while idle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_dump_start) begin
                    w_state_next = (w_lo_al >= w_hi_al) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_grant) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: w_state_next = S_HOLD;
            S_HOLD: begin
                if (w_hs) begin
                    w_state_next = w_range_end ? S_DONE : S_ISSUE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Range, cursor and output-word registers; the word is frozen until accepted.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cursor     <= '0;
            r_hi         <= '0;
            r_dump_addr  <= '0;
            r_dump_data  <= '0;
            r_dump_valid <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && i_dump_start) begin
                r_cursor <= w_lo_al;
                r_hi     <= w_hi_al;
            end
            if (r_state == S_WAIT) begin
                r_dump_data  <= i_mem_rdata;
                r_dump_addr  <= r_cursor;
                r_dump_valid <= 1'b1;
            end
            if ((r_state == S_HOLD) && w_hs) begin
                r_dump_valid <= 1'b0;
                r_cursor     <= w_cursor_inc;
            end
        end
    end

    // Memory port mux: a dump grant wins only when the pipeline is idle or starved out.
    always_comb begin
        o_mem_re    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_be    = 4'h0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (w_grant) begin
            o_mem_re   = 1'b1;
            o_mem_be   = 4'hF;
            o_mem_addr = r_cursor;
        end else if (i_p_req) begin
            o_mem_re    = ~i_p_we;
            o_mem_we    = i_p_we;
            o_mem_be    = i_p_be;
            o_mem_addr  = i_p_addr;
            o_mem_wdata = i_p_wdata;
        end
    end

    assign o_p_rdata    = i_mem_rdata;
    assign o_p_stall    = w_force;
    assign o_dump_valid = r_dump_valid;
    assign o_dump_addr  = r_dump_addr;
    assign o_dump_data  = r_dump_data;
    assign o_dump_busy  = (r_state != S_IDLE);
    assign o_dump_done  = (r_state == S_DONE);

endmodule

// File: tb/tb_dmem_dump_arbiter.sv
// tb/tb_dmem_dump_arbiter.sv - randomized bench for dmem_dump_arbiter with a rule-level model
module tb_dmem_dump_arbiter;
    localparam int LIMIT = 8;
`ifdef DMEM_DUMP_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p_req = 1'b0, p_we = 1'b0;
    logic [3:0]  p_be = 4'h0;
    logic [31:0] p_addr = '0, p_wdata = '0;
    logic [31:0] p_rdata;
    logic        p_stall, mem_re, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        d_start = 1'b0, d_ready = 1'b0;
    logic [31:0] d_lo = '0, d_hi = '0;
    logic        d_valid, d_busy, d_done;
    logic [31:0] d_addr, d_data;

    always #5 clk = ~clk;

    dmem_dump_arbiter #(.XLEN(32), .STARVE_LIMIT(LIMIT)) dut (
        .i_clk(clk), .i_rst(rst_n),
        .i_p_req(p_req), .i_p_we(p_we), .i_p_be(p_be), .i_p_addr(p_addr), .i_p_wdata(p_wdata),
        .o_p_rdata(p_rdata), .o_p_stall(p_stall),
        .o_mem_re(mem_re), .o_mem_we(mem_we), .o_mem_be(mem_be), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
        .i_dump_start(d_start), .i_dump_lo(d_lo), .i_dump_hi(d_hi),
        .o_dump_valid(d_valid), .i_dump_ready(d_ready), .o_dump_addr(d_addr), .o_dump_data(d_data),
        .o_dump_busy(d_busy), .o_dump_done(d_done)
    );

    // Reference contents (model side) and the physical memory driven by the DUT.
    logic [31:0] refm [0:63];
    logic [31:0] mem  [0:63];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) mem[i] <= refm[i];
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        if (mem_re) mem_rdata <= mem[mem_addr[7:2]];
        else        mem_rdata <= $urandom;
    end

    int checks = 0, errors = 0, cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
    endtask

    // Event log for the directed literal checks (taken from DUT pins).
    logic [31:0] hs_addr[$], hs_data[$];
    int          hs_cyc[$];
    int start_cyc = -1, done_cyc = -1, first_grant = -1, grant_cnt = 0, stall_cnt = 0, busy_cnt = 0;

    // Model state: what the dump must be doing, expressed as pending work.
    bit          m_active = 0, m_done = 0, m_inflight = 0, m_gprev = 0, m_vexp = 0;
    logic [31:0] m_next = '0, m_hi = '0, m_waddr = '0, m_wdata = '0;
    int          m_blk = 0;
    bit          wants, forced, grant, hs, nd, st_ok;
    logic [31:0] lo_al, hi_al;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            chk("rst_valid", d_valid, 0);   chk("rst_busy", d_busy, 0);
            chk("rst_done", d_done, 0);     chk("rst_stall", p_stall, 0);
            chk("rst_re", mem_re, 0);       chk("rst_we", mem_we, 0);
            chk("rst_be", mem_be, 0);       chk("rst_addr", mem_addr, 0);
            chk("rst_wdata", mem_wdata, 0); chk("rst_daddr", d_addr, 0);
            chk("rst_ddata", d_data, 0);    chk("rst_prdata", p_rdata, mem_rdata);
            m_active = 0; m_done = 0; m_inflight = 0; m_gprev = 0; m_vexp = 0; m_blk = 0;
        end else begin
            chk("busy", d_busy, m_active);
            chk("done", d_done, m_done);
            chk("p_rdata", p_rdata, mem_rdata);
            wants  = m_active && !m_done && !m_inflight;
            forced = GUARD && wants && p_req && (m_blk == LIMIT);
            grant  = wants && (!p_req || forced);
            chk("stall", p_stall, forced);
            if (grant) begin
                chk("dump_re", mem_re, 1); chk("dump_we", mem_we, 0);
                chk("dump_be", mem_be, 4'hF); chk("dump_maddr", mem_addr, m_next);
            end else if (p_req) begin
                chk("pipe_re", mem_re, !p_we); chk("pipe_we", mem_we, p_we);
                chk("pipe_be", mem_be, p_be); chk("pipe_addr", mem_addr, p_addr);
                chk("pipe_wdata", mem_wdata, p_wdata);
            end else begin
                chk("idle_re", mem_re, 0); chk("idle_we", mem_we, 0);
            end
            chk("dvalid", d_valid, m_vexp);
            if (m_vexp) begin
                chk("daddr", d_addr, m_waddr);
                chk("ddata", d_data, m_wdata);
            end
            if (d_valid && d_ready) begin
                hs_addr.push_back(d_addr); hs_data.push_back(d_data); hs_cyc.push_back(cyc);
            end
            if (d_done) done_cyc = cyc;
            if (d_busy) busy_cnt++;
            if (p_stall) stall_cnt++;
            if (mem_re && (p_stall || !p_req)) begin
                grant_cnt++;
                if (first_grant < 0) first_grant = cyc;
            end
            nd    = 0;
            st_ok = d_start && !m_active;
            hs    = m_vexp && d_ready;
            if (m_done) m_active = 0;
            if (grant) m_blk = 0;
            else if (wants && p_req) m_blk++;
            if (hs) begin
                m_vexp = 0; m_inflight = 0; m_next = m_next + 4;
                if (m_next == 0 || m_next >= m_hi) nd = 1;
            end
            if (m_gprev) m_vexp = 1;
            m_gprev = grant;
            if (grant) begin
                m_inflight = 1; m_waddr = m_next; m_wdata = refm[m_next[7:2]];
            end
            if (p_req && p_we && !forced)
                for (int b = 0; b < 4; b++)
                    if (p_be[b]) refm[p_addr[7:2]][8*b +: 8] = p_wdata[8*b +: 8];
            if (st_ok) begin
                lo_al = {d_lo[31:2], 2'b00}; hi_al = {d_hi[31:2], 2'b00};
                m_active = 1; m_next = lo_al; m_hi = hi_al; start_cyc = cyc;
                if (lo_al >= hi_al) nd = 1;
            end
            m_done = nd;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        hs_addr.delete(); hs_data.delete(); hs_cyc.delete();
        start_cyc = -1; done_cyc = -1; first_grant = -1;
        grant_cnt = 0; stall_cnt = 0; busy_cnt = 0;
    endtask

    task automatic start_dump(input logic [31:0] lo, input logic [31:0] hi);
        d_lo = lo; d_hi = hi; d_start = 1'b1;
        tick();
        d_start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int n = 0;
        while (done_cyc < 0 && n < budget) begin tick(); n++; end
        if (done_cyc < 0) timeout(nm);
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!d_valid && n < 50) begin tick(); n++; end
        if (!d_valid) timeout(nm);
    endtask

    logic [31:0] exp_d [4];
    int          pct;

    initial begin
        for (int i = 0; i < 64; i++) refm[i] = $urandom;
        exp_d = '{32'h11, 32'h22, 32'h33, 32'h44};
        for (int i = 0; i < 4; i++) refm[i] = exp_d[i];
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Four-word dump, pipeline idle, consumer always ready.
        clear_mon(); d_ready = 1'b1;
        start_dump(32'h0, 32'h10);
        wait_done("t1_done", 100);
        chk("t1_words", hs_addr.size(), 4);
        if (hs_addr.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t1_addr", hs_addr[i], 32'(4 * i));
                chk("t1_data", hs_data[i], exp_d[i]);
            end
            chk("t1_last_hs_lat", hs_cyc[3] - start_cyc, 12);
        end
        chk("t1_done_lat", done_cyc - start_cyc, 13);
        chk("t1_busy_cycles", busy_cnt, 13);
        tick();

        // Back-pressure on the first word.
        clear_mon(); d_ready = 1'b0;
        start_dump(32'h0, 32'h8);
        wait_valid("t2_valid");
        repeat (5) tick();
        chk("t2_hold_valid", d_valid, 1);
        chk("t2_hold_addr", d_addr, 32'h0);
        chk("t2_hold_data", d_data, 32'h11);
        chk("t2_single_read", grant_cnt, 1);
        d_ready = 1'b1;
        wait_done("t2_done", 100);
        chk("t2_words", hs_addr.size(), 2);
        tick();

        // Empty range.
        clear_mon();
        start_dump(32'h20, 32'h20);
        wait_done("t3_done", 10);
        chk("t3_done_lat", done_cyc - start_cyc, 1);
        chk("t3_busy_cycles", busy_cnt, 1);
        chk("t3_reads", grant_cnt, 0);
        tick();

        // Pipeline holds the port for 20 cycles.
        clear_mon();
        p_req = 1'b1; p_we = 1'b0; p_be = 4'hF; p_addr = 32'h80;
        start_dump(32'h10, 32'h14);
        repeat (19) tick();
        p_req = 1'b0;
        wait_done("t4_done", 100);
        chk("t4_first_read", first_grant - start_cyc, GUARD ? 9 : 20);
        chk("t4_stalls", stall_cnt, GUARD ? 1 : 0);
        tick();

        // Pipeline store lands before the dump reads the same word.
        clear_mon();
        start_dump(32'h0, 32'h8);
        p_req = 1'b1; p_we = 1'b1; p_be = 4'hF; p_addr = 32'h4; p_wdata = 32'hDEADBEEF;
        tick();
        p_req = 1'b0; p_we = 1'b0;
        wait_done("t5_done", 100);
        chk("t5_first_read", first_grant - start_cyc, 2);
        if (hs_addr.size() == 2) begin
            chk("t5_addr1", hs_addr[1], 32'h4);
            chk("t5_data1", hs_data[1], 32'hDEADBEEF);
        end else chk("t5_words", hs_addr.size(), 2);
        tick();

        // Reset while a word is held.
        clear_mon(); d_ready = 1'b0;
        start_dump(32'h30, 32'h40);
        wait_valid("t6_valid");
        clear_mon();
        rst_n = 1'b0;
        #1;
        chk("t6_valid", d_valid, 0); chk("t6_busy", d_busy, 0);
        chk("t6_daddr", d_addr, 0);  chk("t6_ddata", d_data, 0);
        chk("t6_re", mem_re, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("t6_no_done", done_cyc, -1);
        d_ready = 1'b1;
        start_dump(32'h40, 32'h48);
        wait_done("t6_done", 100);
        chk("t6_words", hs_addr.size(), 2);
        if (hs_addr.size() > 0) chk("t6_first_addr", hs_addr[0], 32'h40);
        tick();

        // High-address range ends cleanly without overflow.
        clear_mon();
        start_dump(32'hFFFF_FFF0, 32'hFFFF_FFFF);
        wait_done("t7_done", 100);
        chk("t7_words", hs_addr.size(), 3);
        tick();

        // Randomized traffic against the model.
        pct = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) pct = (c / 200) % 4 * 33;
            if (c == 2000 || c == 2001) begin
                rst_n = 1'b0; p_req = 1'b0; d_start = 1'b0;
            end else begin
                rst_n   = 1'b1;
                p_req   = ($urandom_range(0, 99) < pct);
                p_we    = $urandom_range(0, 1);
                p_be    = $urandom;
                p_addr  = {24'h0, 6'($urandom), 2'b00};
                p_wdata = $urandom;
                d_ready = ($urandom_range(0, 99) < 70);
                d_start = ($urandom_range(0, 99) < 4);
                d_lo    = $urandom_range(0, 32'h110);
                d_hi    = $urandom_range(0, 32'h110);
                if ($urandom_range(0, 9) == 0) begin
                    d_lo = d_lo | 32'hFFFF_FF00;
                    d_hi = d_hi | 32'hFFFF_FF00;
                end
            end
            tick();
        end
        p_req = 1'b0; d_start = 1'b0; d_ready = 1'b1; rst_n = 1'b1;
        for (int n = 0; n < 300 && d_busy; n++) tick();
        if (d_busy) timeout("drain");
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
